ir_beat_assembler: RTL and testbench

//  Parametrised instruction-register loader. Assembles one BEATS*DATA_W-bit opcode/address

---
 rtl/ir_beat_if.sv | 40 ++++
 rtl/ir_beat_assembler.sv | 97 +++++++++
 tb/tb_ir_beat_assembler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ir_beat_if.sv
// Bus bundle for the instruction-register beat assembler.
// Parity signals exist only when IR_PARITY_EN is defined.
interface ir_beat_if #(
    parameter int DATA_W = 8,
    parameter int BEATS  = 2
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                     ena;
    logic                     clr;
    logic [DATA_W-1:0]        data;
    logic [DATA_W*BEATS-1:0]  opc_iraddr;
    logic                     ir_valid;
    logic                     ir_busy;
    logic [CW-1:0]            beat_cnt;
`ifdef IR_PARITY_EN
    logic                     data_par;
    logic                     par_err;
`endif

`ifdef IR_PARITY_EN
    modport master (
        output ena, clr, data, data_par,
        input  opc_iraddr, ir_valid, ir_busy, beat_cnt, par_err
    );
    modport slave (
        input  ena, clr, data, data_par,
        output opc_iraddr, ir_valid, ir_busy, beat_cnt, par_err
    );
`else
    modport master (
        output ena, clr, data,
        input  opc_iraddr, ir_valid, ir_busy, beat_cnt
    );
    modport slave (
        input  ena, clr, data,
        output opc_iraddr, ir_valid, ir_busy, beat_cnt
    );
`endif
endinterface

// File: rtl/ir_beat_assembler.sv
// Instruction-register loader: packs BEATS data-bus beats into one word.
// Optional IR_PARITY_EN adds even-parity checking of each beat (data_par/par_err).
module ir_beat_assembler #(
    parameter int DATA_W    = 8,
    parameter int BEATS     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic      clk1,
    input logic      rst_n,
    ir_beat_if.slave bus
);
    localparam int W  = DATA_W * BEATS;
    localparam int CW = $clog2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic [W-1:0]  MASK = W'({DATA_W{1'b1}});

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] slot;
    logic [W-1:0]  shadow_q;
    logic [W-1:0]  shadow_d;
    logic [W-1:0]  opc_q;
    logic [W-1:0]  opc_d;
    logic [W-1:0]  merged;
    logic          valid_q;
    logic          valid_d;
    logic          legal;
    logic          last;
    logic          beat_ok;
    logic          take;
    int            lo;
`ifdef IR_PARITY_EN
    logic          perr_q;
    logic          perr_d;
`endif

    // Decide whether this edge consumes a beat and what the next state is.
    always_comb begin
        legal = (cnt_q <= LAST);
        last  = (cnt_q == LAST);
        slot  = MSB_FIRST ? (LAST - cnt_q) : cnt_q;
        lo    = int'(slot) * DATA_W;
`ifdef IR_PARITY_EN
        beat_ok = (bus.data_par == ^bus.data);
`else
        beat_ok = 1'b1;
`endif
        take     = bus.ena && !bus.clr && legal && beat_ok;
        merged   = (shadow_q & ~(MASK << lo)) | (W'(bus.data) << lo);
        cnt_d    = (take && !last) ? cnt_q + CW'(1) : '0;
        shadow_d = take ? merged : shadow_q;
        opc_d    = (take && last) ? merged : opc_q;
        valid_d  = take && last;
`ifdef IR_PARITY_EN
        perr_d = perr_q;
        if (bus.clr) begin
            perr_d = 1'b0;
        end else if (bus.ena && !beat_ok) begin
            perr_d = 1'b1;
        end
`endif
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            opc_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            opc_q    <= opc_d;
            valid_q  <= valid_d;
        end
    end

`ifdef IR_PARITY_EN
    // Sticky parity error flag, cleared only by clr or reset.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.par_err = perr_q;
`endif

    assign bus.opc_iraddr = opc_q;
    assign bus.ir_valid   = valid_q;
    assign bus.ir_busy    = (cnt_q != '0);
    assign bus.beat_cnt   = cnt_q;

endmodule

// File: tb/tb_ir_beat_assembler.sv
// Randomised scoreboard bench for ir_beat_assembler.
// A second instance covers the 3-beat LSB-first configuration.
module tb_ir_beat_assembler;
    localparam int NB   = 2;
    localparam bit MSBF = 1'b1;
`ifdef IR_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk1 = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk1 = ~clk1;

    ir_beat_if #(.DATA_W(8), .BEATS(2)) bus ();
    ir_beat_if #(.DATA_W(8), .BEATS(3)) bus3 ();

    ir_beat_assembler #(.DATA_W(8), .BEATS(2), .MSB_FIRST(1'b1)) dut (
        .clk1(clk1), .rst_n(rst_n), .bus(bus)
    );

    ir_beat_assembler #(.DATA_W(8), .BEATS(3), .MSB_FIRST(1'b0)) dut3 (
        .clk1(clk1), .rst_n(rst_n), .bus(bus3)
    );

    int          total = 0;
    int          bad = 0;
    logic [15:0] expq[$];
    logic [7:0]  pend[$];
    logic [15:0] last_word = '0;
    bit          perr_m = 1'b0;
    bit          vexp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Reference word: first collected beat lands in the top or bottom slice.
    function automatic logic [15:0] build();
        logic [15:0] w;
        w = '0;
        foreach (pend[i]) begin
            if (MSBF) w = (w << 8) | 16'(pend[i]);
            else      w = w | (16'(pend[i]) << (8 * i));
        end
        return w;
    endfunction

    // One clock: check state left by the last edge, then drive the next beat.
    task automatic cyc(input bit e, input bit c, input logic [7:0] d,
                       input bit badp);
        bit bp;
        @(negedge clk1);
        chk("beat_cnt", 32'(bus.beat_cnt), pend.size());
        chk("ir_busy", 32'(bus.ir_busy), 32'(pend.size() != 0));
        chk("opc_hold", 32'(bus.opc_iraddr), 32'(last_word));
        chk("ir_valid", 32'(bus.ir_valid), 32'(vexp));
`ifdef IR_PARITY_EN
        chk("par_err", 32'(bus.par_err), 32'(perr_m));
        bus.data_par = (^d) ^ badp;
`endif
        bus.ena  = e;
        bus.clr  = c;
        bus.data = d;
        bp   = badp & PAR;
        vexp = 1'b0;
        if (c) begin
            pend.delete();
            perr_m = 1'b0;
        end else if (e) begin
            if (bp) begin
                pend.delete();
                perr_m = 1'b1;
            end else begin
                pend.push_back(d);
                if (pend.size() == NB) begin
                    last_word = build();
                    expq.push_back(last_word);
                    pend.delete();
                    vexp = 1'b1;
                end
            end
        end else begin
            pend.delete();
        end
    endtask

    // Scoreboard monitor: every ir_valid pulse must match the oldest expected word.
    always @(negedge clk1) begin
        if (rst_n && bus.ir_valid) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid got=%0h want=none",
                         bus.opc_iraddr);
            end else begin
                chk("ir_word", 32'(bus.opc_iraddr), 32'(expq.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ena = 1'b0;
        bus.clr = 1'b0;
        bus.data = '0;
        bus3.ena = 1'b0;
        bus3.clr = 1'b0;
        bus3.data = '0;
`ifdef IR_PARITY_EN
        bus.data_par = 1'b0;
        bus3.data_par = 1'b0;
`endif
        #2;
        chk("rst_opc", 32'(bus.opc_iraddr), 0);
        chk("rst_valid", 32'(bus.ir_valid), 0);
        chk("rst_busy", 32'(bus.ir_busy), 0);
        chk("rst_cnt", 32'(bus.beat_cnt), 0);
        @(negedge clk1);
        rst_n = 1'b1;

        // Three beats, least-significant first.
        @(negedge clk1);
        bus3.ena = 1'b1;
        bus3.data = 8'h11;
`ifdef IR_PARITY_EN
        bus3.data_par = ^8'h11;
`endif
        @(negedge clk1);
        chk("b3_busy1", 32'(bus3.ir_busy), 1);
        chk("b3_cnt1", 32'(bus3.beat_cnt), 1);
        bus3.data = 8'h22;
`ifdef IR_PARITY_EN
        bus3.data_par = ^8'h22;
`endif
        @(negedge clk1);
        chk("b3_busy2", 32'(bus3.ir_busy), 1);
        chk("b3_cnt2", 32'(bus3.beat_cnt), 2);
        bus3.data = 8'h33;
`ifdef IR_PARITY_EN
        bus3.data_par = ^8'h33;
`endif
        @(negedge clk1);
        bus3.ena = 1'b0;
        chk("b3_word", 32'(bus3.opc_iraddr), 32'h332211);
        chk("b3_valid", 32'(bus3.ir_valid), 1);
        chk("b3_idle", 32'(bus3.ir_busy), 0);
        @(negedge clk1);
        chk("b3_pulse", 32'(bus3.ir_valid), 0);
        chk("b3_hold", 32'(bus3.opc_iraddr), 32'h332211);

        // Two-beat word.
        cyc(1, 0, 8'hA5, 0);
        cyc(1, 0, 8'h3C, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);

        // Back-to-back words with no bubble.
        cyc(1, 0, 8'h01, 0);
        cyc(1, 0, 8'h02, 0);
        cyc(1, 0, 8'h03, 0);
        cyc(1, 0, 8'h04, 0);
        cyc(0, 0, 8'h00, 0);

        // Gap in ena abandons the partial word.
        cyc(1, 0, 8'hFF, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(1, 0, 8'h12, 0);
        cyc(1, 0, 8'h34, 0);
        cyc(0, 0, 8'h00, 0);

        // Asynchronous reset in the middle of a word.
        cyc(0, 0, 8'h00, 0);
        cyc(1, 0, 8'h77, 0);
        @(negedge clk1);
        bus.ena = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_opc", 32'(bus.opc_iraddr), 0);
        chk("arst_cnt", 32'(bus.beat_cnt), 0);
        chk("arst_busy", 32'(bus.ir_busy), 0);
        chk("arst_valid", 32'(bus.ir_valid), 0);
        pend.delete();
        last_word = '0;
        perr_m = 1'b0;
        vexp = 1'b0;
        @(negedge clk1);
        #2;
        rst_n = 1'b1;
        cyc(1, 0, 8'h9A, 0);
        cyc(1, 0, 8'hBC, 0);
        cyc(0, 0, 8'h00, 0);

        // clr beats ena mid-word.
        cyc(1, 0, 8'h5A, 0);
        cyc(1, 1, 8'hC3, 0);
        cyc(1, 0, 8'h21, 0);
        cyc(1, 0, 8'h43, 0);
        cyc(0, 0, 8'h00, 0);

`ifdef IR_PARITY_EN
        cyc(1, 0, 8'h55, 0);
        cyc(1, 0, 8'h66, 1);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
`endif

        repeat (400) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                8'($urandom), $urandom_range(0, 9) == 0);
        end
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        chk("queue_empty", 32'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
